// File: rtl/uart_send_pkg.sv
// Shared UART timing constants and transmitter state encoding.
// The receiver imports the same definitions so both ends agree on bit timing.
package uart_send_pkg;

    localparam int unsigned CLK_FREQ  = 100_000_000;
    localparam int unsigned BAUD_RATE = 9600;
    localparam int unsigned BAUD_END  = CLK_FREQ / BAUD_RATE - 1;
    localparam int unsigned BAUD_HALF = BAUD_END / 2;

    // Wide enough for BAUD_END at 100 MHz / 9600 baud.
    localparam int unsigned CNT_W = 14;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StStart = 2'd1,
        StData  = 2'd2,
        StStop  = 2'd3
    } tx_state_e;

    function automatic int unsigned baud_end(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        return clk_freq / baud_rate - 1;
    endfunction

endpackage

// File: rtl/uart_send_if.sv
// Byte handshake between the controller (master) and the UART transmitter (slave).
interface uart_send_if;

    logic       valid;
    logic [7:0] data;
    logic       ready;
    logic       done;

    modport master (
        output valid,
        output data,
        input  ready,
        input  done
    );

    modport slave (
        input  valid,
        input  data,
        output ready,
        output done
    );

endinterface

// File: rtl/uart_send_baud_tick.sv
// Bit-period counter: one-cycle tick every BaudEnd+1 clocks while enabled, held at zero otherwise.
module uart_send_baud_tick
    import uart_send_pkg::*;
#(
    parameter int unsigned BaudEnd = BAUD_END
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             tick_o
);

    localparam logic [CNT_W-1:0] EndVal = CNT_W'(BaudEnd);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en_i || tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && (cnt_q == EndVal);
    assign cnt_o  = cnt_q;

endmodule

// File: rtl/uart_send.sv
// 8N1 UART transmitter, LSB first. All outputs are flops; the next accepted byte's start bit
// follows the stop bit directly when valid arrives in the done cycle.
module uart_send
    import uart_send_pkg::*;
#(
    parameter int unsigned ClkFreq  = CLK_FREQ,
    parameter int unsigned BaudRate = BAUD_RATE
) (
    input  logic        clk,
    input  logic        rst,
    uart_send_if.slave  tx,
    output logic        dout
);

    localparam int unsigned      BaudEnd = baud_end(ClkFreq, BaudRate);
    localparam logic [CNT_W-1:0] PreEnd  = CNT_W'(BaudEnd - 1);

    tx_state_e        state_q, state_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic             dout_q, dout_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             accept;
    logic             tick;
    logic [CNT_W-1:0] cnt;

    uart_send_baud_tick #(
        .BaudEnd (BaudEnd)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .en_i   (state_q != StIdle),
        .cnt_o  (cnt),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        ready_d = ready_q;
        done_d  = 1'b0;
        dout_d  = 1'b1;
        accept  = 1'b0;

        unique case (state_q)
            StIdle: begin
                accept = tx.valid && ready_q;
            end
            StStart: begin
                if (tick) state_d = StData;
            end
            StData: begin
                if (tick) begin
                    if (bit_q == 3'd7) state_d = StStop;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            StStop: begin
                // Flag completion in the last stop cycle so a new byte can start without a gap.
                if (cnt == PreEnd) begin
                    done_d  = 1'b1;
                    ready_d = 1'b1;
                end
                if (tick) begin
                    state_d = StIdle;
                    accept  = tx.valid && ready_q;
                end
            end
        endcase

        if (accept) begin
            shift_d = tx.data;
            bit_d   = 3'd0;
            ready_d = 1'b0;
            state_d = StStart;
        end

        // Line level follows the state being entered, so dout stays a pure flop output.
        unique case (state_d)
            StIdle:  dout_d = 1'b1;
            StStart: dout_d = 1'b0;
            StData:  dout_d = shift_d[bit_d];
            StStop:  dout_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            dout_q  <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            dout_q  <= dout_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    assign dout     = dout_q;
    assign tx.ready = ready_q;
    assign tx.done  = done_q;

endmodule

// File: doc/uart_send.md
Name: uart_send

Overview:
UART transmitter, 8N1 framing, LSB first, at a fixed baud rate derived from the system clock. It accepts one byte per valid pulse, serialises it onto the usb_uart tx pin and reports completion. It is the companion to the existing UART receiver, shares its timing constants, and is driven by the same top-level controller.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz
BAUD_RATE, 9600, line rate in bit/s
BAUD_END, CLK_FREQ/BAUD_RATE-1 (10415), last count value of one bit period

Ports:
clk    input   1  system clock, 100 MHz
rst    input   1  asynchronous reset, active-high
valid  input   1  request to send; sampled only while ready=1
data   input   8  byte to send; captured in the cycle valid&ready
dout   output  1  serial line to the usb_uart tx pin; idles high
ready  output  1  high when a new byte may be accepted
done   output  1  single-cycle pulse after the stop bit completes

Behaviour:
- Reset (async, rst=1): state=IDLE, dout=1, ready=1, done=0, baud_counter=0, bit_index=0, shift register=0. Asserting reset mid-frame aborts the frame immediately. The line returns high with no partial stop bit.
- States: IDLE, START, DATA, STOP. Three-process FSM: state register, next-state logic, registered outputs.
- IDLE
  - dout=1, ready=1, done=0.
  - On valid=1: latch data into shift_reg, clear baud_counter and bit_index, set ready=0, go to START.
  - valid is ignored whenever ready=0; no queuing, no error flag.
- START
  - dout=0 for exactly BAUD_END+1 clocks (10416).
  - At baud_counter==BAUD_END: clear the counter and go to DATA.
- DATA
  - dout=shift_reg[bit_index] held for BAUD_END+1 clocks per bit.
  - At the end of each bit: if bit_index==7, go to STOP; otherwise increment bit_index and clear the counter.
- STOP
  - dout=1 for BAUD_END+1 clocks.
  - At the end of the stop bit: done=1 for exactly one clock, ready=1, go to IDLE.
- Timing
  - The first edge of the start bit appears on dout one clock after the valid&ready cycle, because dout is registered.
  - Total frame is 10×10416 = 104160 clocks from the start edge to the first cycle dout may fall again.
- Back-to-back sends
  - valid may be asserted in the cycle done=1, since ready=1 in that cycle.
  - The byte is accepted and the next start bit follows with no extra idle bit.
- Data stability: a change on data after capture has no effect on the frame in progress.
- Widths: baud_counter is 14 bits and never exceeds BAUD_END; bit_index is 3 bits and does not wrap past 7.
- Glitch-free output: dout comes directly from a flop, never from a combinational path.

Decomposition:
- Shared package/header (uart_defs): CLK_FREQ, BAUD_RATE, BAUD_END, BAUD_HALF, and the state encodings IDLE=0, START=1, DATA=2, STOP=3. The receiver imports the same definitions.
- Optional sub-module baud_tick: a counter producing a one-cycle tick every BAUD_END+1 clocks while enabled, cleared when disabled. It is natural to share with the receiver later; inlining is acceptable for this block.

Test Plan:
1. Reset then idle: rst pulse, no valid for 1000 clocks -> dout=1, ready=1, done=0 throughout.
2. Single byte 8'hA5 -> dout sequence 0,1,0,1,0,0,1,0,1,1, each level held exactly 10416 clocks; one done pulse at the end; ready low for 104160 clocks.
3. Back-to-back 8'h00 then 8'hFF, second valid asserted in the done cycle -> second start edge immediately follows the first stop bit (10416 high clocks, no extra); frames decode as 00, FF.
4. valid pulsed with 8'h3C mid-frame while sending 8'h55 -> ignored; only 8'h55 is transmitted; exactly one done pulse.
5. data changed to 8'hFF one clock after capturing 8'h12 -> the line still carries 8'h12.
6. rst asserted during DATA bit 4 -> dout=1 and ready=1 in the same cycle, asynchronously; a subsequent send of 8'h81 transmits correctly.
7. Loopback: uart_send.dout wired to uart_recv.din, bytes 00, 55, AA, FF, 7E sent -> receiver valid pulses with matching data in order.
